// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl
//   SCAN-order car motion controller for a 4-floor car. Latches call
//   buttons, keeps travelling in one direction while calls remain ahead,
//   then reverses. Emits one-cycle inc_floor/red_floor step pulses to the
//   floor counter, reads cur_floor back, and holds the door open at each
//   served floor. All outputs are registered.
module elevator_motion_ctrl #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       floor_clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [1:0] cur_floor,
    output logic       inc_floor,
    output logic       red_floor,
    output logic       door_open,
    output logic       dir_up,
    output logic       moving,
    output logic [3:0] pending
);

    // One shared timer serves both MOVE and DOOR; size it for the longer one.
    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOVE   = 3'd1,
        S_STEP   = 3'd2,
        S_SETTLE = 3'd3,
        S_DOOR   = 3'd4
    } state_t;

    // Floors strictly above f (unsigned compare).
    function automatic logic [3:0] mask_above(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (2'(i) > f);
        end
        return m;
    endfunction

    // Floors strictly below f (unsigned compare).
    function automatic logic [3:0] mask_below(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (2'(i) < f);
        end
        return m;
    endfunction

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic            r_dir;
    logic            r_inc;
    logic            r_red;
    logic            r_door;
    logic            r_moving;
    logic [3:0]      r_pending;

    state_t          w_nxt_state;
    logic [TW-1:0]   w_nxt_timer;
    logic            w_nxt_dir;
    logic            w_nxt_inc;
    logic            w_nxt_red;
    logic            w_nxt_door;
    logic            w_nxt_moving;
    logic [3:0]      w_nxt_pending;
    logic [3:0]      w_req_lat;

    logic            w_here;
    logic            w_above;
    logic            w_below;
    logic            w_fwd;
    logic            w_back;

    // Above/below never include cur_floor itself, so the door-expiry
    // decision automatically ignores the call at the current floor.
    assign w_here  = r_pending[cur_floor];
    assign w_above = |(r_pending & mask_above(cur_floor));
    assign w_below = |(r_pending & mask_below(cur_floor));
    assign w_fwd   = r_dir ? w_above : w_below;
    assign w_back  = r_dir ? w_below : w_above;

    // Next-state, timer, direction and step-pulse decisions.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_dir   = r_dir;
        w_nxt_inc   = 1'b0;
        w_nxt_red   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nxt_timer = '0;
                if (w_here) begin
                    w_nxt_state = S_DOOR;
                end else if (w_above) begin
                    w_nxt_state = S_MOVE;
                    w_nxt_dir   = 1'b1;
                end else if (w_below) begin
                    w_nxt_state = S_MOVE;
                    w_nxt_dir   = 1'b0;
                end
            end
            S_MOVE: begin
                if (r_timer == TRAVEL_LAST) begin
                    w_nxt_state = S_STEP;
                    w_nxt_timer = '0;
                    // Never step past the top or bottom floor.
                    if (r_dir) begin
                        w_nxt_inc = (cur_floor != 2'd3);
                    end else begin
                        w_nxt_red = (cur_floor != 2'd0);
                    end
                end else begin
                    w_nxt_timer = r_timer + TW'(1);
                end
            end
            S_STEP: begin
                w_nxt_timer = '0;
                // A suppressed pulse means the step was illegal: give up and re-plan from IDLE.
                w_nxt_state = (r_inc || r_red) ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: begin
                w_nxt_timer = '0;
                if (w_here) begin
                    w_nxt_state = S_DOOR;
                end else if (w_fwd) begin
                    w_nxt_state = S_MOVE;
                end else if (w_back) begin
                    w_nxt_state = S_MOVE;
                    w_nxt_dir   = ~r_dir;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_DOOR: begin
                if (req[cur_floor]) begin
                    w_nxt_timer = '0;
                end else if (r_timer == DOOR_LAST) begin
                    w_nxt_timer = '0;
                    if (w_fwd) begin
                        w_nxt_state = S_MOVE;
                    end else if (w_back) begin
                        w_nxt_state = S_MOVE;
                        w_nxt_dir   = ~r_dir;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_timer = r_timer + TW'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_timer = '0;
            end
        endcase
    end

    // Call latch: the button at an open door only holds the door, and the
    // served floor's call is dropped on the edge that opens the door.
    always_comb begin
        w_req_lat = req;
        if (r_state == S_DOOR) begin
            w_req_lat[cur_floor] = 1'b0;
        end
        w_nxt_pending = r_pending | w_req_lat;
        if ((w_nxt_state == S_DOOR) && (r_state != S_DOOR)) begin
            w_nxt_pending[cur_floor] = 1'b0;
        end
    end

    assign w_nxt_door   = (w_nxt_state == S_DOOR);
    assign w_nxt_moving = (w_nxt_state == S_MOVE) || (w_nxt_state == S_STEP) ||
                          (w_nxt_state == S_SETTLE);

    // State, timer and direction registers.
    always_ff @(posedge floor_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_timer <= w_nxt_timer;
            r_dir   <= w_nxt_dir;
        end
    end

    // Registered outputs and the latched call set.
    always_ff @(posedge floor_clk or posedge rst) begin
        if (rst) begin
            r_inc     <= 1'b0;
            r_red     <= 1'b0;
            r_door    <= 1'b0;
            r_moving  <= 1'b0;
            r_pending <= 4'b0000;
        end else begin
            r_inc     <= w_nxt_inc;
            r_red     <= w_nxt_red;
            r_door    <= w_nxt_door;
            r_moving  <= w_nxt_moving;
            r_pending <= w_nxt_pending;
        end
    end

    assign inc_floor = r_inc;
    assign red_floor = r_red;
    assign door_open = r_door;
    assign dir_up    = r_dir;
    assign moving    = r_moving;
    assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb_elevator_motion_ctrl
//   Directed bench: a cycle-by-cycle vector table for the basic door and
//   single-floor trip cases, followed by hand-written sequences for SCAN
//   ordering, reversal, the top-floor step guard and asynchronous reset.
//   A behavioural floor counter closes the loop on cur_floor.
module tb_elevator_motion_ctrl;

    logic       floor_clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] cur_floor;
    logic       inc_floor;
    logic       red_floor;
    logic       door_open;
    logic       dir_up;
    logic       moving;
    logic [3:0] pending;

    logic [1:0] m_floor;
    logic       ovr_en;
    logic [1:0] ovr_floor;

    int checks;
    int failures;

    logic       mon_clr;
    int         n_inc;
    int         n_red;
    int         n_both;
    int         door_n;
    logic [1:0] door_log [8];
    logic       prev_door;

    // exp packs {inc, red, door, dir, moving, pending[3:0], cur_floor[1:0]}
    typedef struct {
        logic [3:0]  req;
        logic [10:0] exp;
    } vec_t;

    vec_t vt [30];

    elevator_motion_ctrl #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .floor_clk(floor_clk),
        .rst      (rst),
        .req      (req),
        .cur_floor(cur_floor),
        .inc_floor(inc_floor),
        .red_floor(red_floor),
        .door_open(door_open),
        .dir_up   (dir_up),
        .moving   (moving),
        .pending  (pending)
    );

    initial floor_clk = 1'b0;
    always #5 floor_clk = ~floor_clk;

    // Floor counter model sharing the controller's reset.
    always @(posedge floor_clk or posedge rst) begin
        if (rst) begin
            m_floor <= 2'd0;
        end else if (inc_floor && m_floor != 2'd3) begin
            m_floor <= m_floor + 2'd1;
        end else if (red_floor && m_floor != 2'd0) begin
            m_floor <= m_floor - 2'd1;
        end
    end

    assign cur_floor = ovr_en ? ovr_floor : m_floor;

    // Pulse counters and a log of floors where the door opened.
    always @(posedge floor_clk) begin
        if (mon_clr) begin
            n_inc     <= 0;
            n_red     <= 0;
            n_both    <= 0;
            door_n    <= 0;
            prev_door <= 1'b0;
        end else begin
            if (inc_floor) n_inc <= n_inc + 1;
            if (red_floor) n_red <= n_red + 1;
            if (inc_floor && red_floor) n_both <= n_both + 1;
            if (door_open && !prev_door && door_n < 8) begin
                door_log[door_n] <= cur_floor;
                door_n           <= door_n + 1;
            end
            prev_door <= door_open;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge floor_clk);
        @(negedge floor_clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!moving && !door_open && pending == 4'b0000) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        ovr_en    = 1'b0;
        ovr_floor = 2'd0;
        mon_clr   = 1'b1;

        // Door at floor 0, then a one-floor trip up, then a door restart at floor 2.
        vt[0]  = '{4'b0001, 11'b00000_0001_00};
        vt[1]  = '{4'b0000, 11'b00100_0000_00};
        vt[2]  = '{4'b0000, 11'b00100_0000_00};
        vt[3]  = '{4'b0000, 11'b00100_0000_00};
        vt[4]  = '{4'b0000, 11'b00000_0000_00};
        vt[5]  = '{4'b0010, 11'b00000_0010_00};
        vt[6]  = '{4'b0000, 11'b00011_0010_00};
        vt[7]  = '{4'b0000, 11'b00011_0010_00};
        vt[8]  = '{4'b0000, 11'b00011_0010_00};
        vt[9]  = '{4'b0000, 11'b00011_0010_00};
        vt[10] = '{4'b0000, 11'b10011_0010_00};
        vt[11] = '{4'b0000, 11'b00011_0010_01};
        vt[12] = '{4'b0000, 11'b00110_0000_01};
        vt[13] = '{4'b0000, 11'b00110_0000_01};
        vt[14] = '{4'b0000, 11'b00110_0000_01};
        vt[15] = '{4'b0000, 11'b00010_0000_01};
        vt[16] = '{4'b0100, 11'b00010_0100_01};
        vt[17] = '{4'b0000, 11'b00011_0100_01};
        vt[18] = '{4'b0000, 11'b00011_0100_01};
        vt[19] = '{4'b0000, 11'b00011_0100_01};
        vt[20] = '{4'b0000, 11'b00011_0100_01};
        vt[21] = '{4'b0000, 11'b10011_0100_01};
        vt[22] = '{4'b0000, 11'b00011_0100_10};
        vt[23] = '{4'b0000, 11'b00110_0000_10};
        vt[24] = '{4'b0000, 11'b00110_0000_10};
        vt[25] = '{4'b0000, 11'b00110_0000_10};
        vt[26] = '{4'b0100, 11'b00110_0000_10};
        vt[27] = '{4'b0000, 11'b00110_0000_10};
        vt[28] = '{4'b0000, 11'b00110_0000_10};
        vt[29] = '{4'b0000, 11'b00010_0000_10};

        #12;
        chk("reset_outputs",
            32'({inc_floor, red_floor, door_open, dir_up, moving, pending}), 32'd0);
        @(negedge floor_clk);
        rst     = 1'b0;
        mon_clr = 1'b0;

        for (int i = 0; i < 30; i++) begin
            req = vt[i].req;
            tick();
            chk($sformatf("vec%0d", i),
                32'({inc_floor, red_floor, door_open, dir_up, moving, pending, cur_floor}),
                32'(vt[i].exp));
        end
        req = 4'b0000;

        // Asynchronous reset in the middle of a trip.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("rst_pre_moving", 32'({moving, dir_up, pending}), 32'({1'b1, 1'b1, 4'b0100}));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs",
            32'({inc_floor, red_floor, door_open, dir_up, moving, pending}), 32'd0);
        @(negedge floor_clk);
        rst = 1'b0;
        chk("rst_release_idle", 32'({moving, door_open, pending, cur_floor}), 32'd0);
        tick();
        tick();
        tick();
        chk("rst_stays_idle", 32'({moving, door_open, pending, inc_floor}), 32'd0);

        // SCAN upward: serve floor 1, pass floor 2, serve floor 3.
        mon_clr = 1'b1;
        req     = 4'b1010;
        tick();
        mon_clr = 1'b0;
        req     = 4'b0000;
        wait_idle(200, "scan_up_done");
        chk("scan_up_doors", 32'(door_n), 32'd2);
        chk("scan_up_first_stop", 32'(door_log[0]), 32'd1);
        chk("scan_up_second_stop", 32'(door_log[1]), 32'd3);
        chk("scan_up_inc_count", 32'(n_inc), 32'd3);
        chk("scan_up_red_count", 32'(n_red), 32'd0);
        chk("scan_up_at_top", 32'({cur_floor, dir_up}), 32'({2'd3, 1'b1}));

        // Reverse from floor 3 down to floor 0.
        mon_clr = 1'b1;
        req     = 4'b0001;
        tick();
        mon_clr = 1'b0;
        req     = 4'b0000;
        tick();
        chk("reverse_dir_flip", 32'({dir_up, moving}), 32'({1'b0, 1'b1}));
        wait_idle(200, "reverse_done");
        chk("reverse_red_count", 32'(n_red), 32'd3);
        chk("reverse_inc_count", 32'(n_inc), 32'd0);
        chk("reverse_door_floor", 32'({door_n[3:0], door_log[0]}), 32'({4'd1, 2'd0}));
        chk("reverse_at_bottom", 32'(cur_floor), 32'd0);
        chk("never_both_pulses", 32'(n_both), 32'd0);

        // Step guard: cur_floor jumps to 3 during an upward MOVE.
        mon_clr   = 1'b1;
        ovr_en    = 1'b1;
        ovr_floor = 2'd2;
        tick();
        mon_clr = 1'b0;
        req     = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        chk("guard_move_up", 32'({moving, dir_up}), 32'({1'b1, 1'b1}));
        ovr_floor = 2'd3;
        tick();
        tick();
        tick();
        tick();
        chk("guard_step_no_inc", 32'({moving, inc_floor, red_floor}), 32'({1'b1, 1'b0, 1'b0}));
        tick();
        chk("guard_back_to_idle", 32'({moving, door_open}), 32'd0);
        tick();
        chk("guard_door_at_3", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
        chk("guard_no_pulses", 32'(n_inc + n_red), 32'd0);
        wait_idle(20, "guard_done");
        ovr_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
